// File: rtl/wb_pkg.sv
// Shared write-back definitions: register-file write modes, queue entry layout
// and the byte/pair alignment applied when a result is captured.
package wb_pkg;

    localparam int WB_DEPTH  = 2;
    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;

    localparam logic [1:0] WM_NONE = 2'b00;
    localparam logic [1:0] WM_LO   = 2'b01;
    localparam logic [1:0] WM_HI   = 2'b10;
    localparam logic [1:0] WM_WORD = 2'b11;

    typedef struct packed {
        logic [1:0]           mode;
        logic [WB_ADDR_W-1:0] rd0;
        logic [WB_ADDR_W-1:0] rd1;
        logic [WB_DATA_W-1:0] data0;
        logic [WB_DATA_W-1:0] data1;
    } wb_entry_t;

    // Unused fields are zeroed so nothing undefined ever reaches the register file.
    function automatic wb_entry_t align_entry(
        input logic [1:0]           mode,
        input logic [WB_ADDR_W-1:0] rd0,
        input logic [WB_ADDR_W-1:0] rd1,
        input logic [WB_DATA_W-1:0] d0,
        input logic [WB_DATA_W-1:0] d1
    );
        wb_entry_t e;
        e      = '0;
        e.mode = mode;
        e.rd0  = rd0;
        case (mode)
            WM_LO:   e.data0 = {8'h00, d0[7:0]};
            WM_HI:   e.data0 = {d0[7:0], 8'h00};
            WM_WORD: begin
                e.data0 = d0;
                // A duplicate or absent secondary collapses to a single write.
                if ((rd1 != rd0) && (rd1 != '0)) begin
                    e.rd1   = rd1;
                    e.data1 = d1;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic in-order queue with separate count; exposes every slot and its
// validity so callers can build occupancy-based summaries.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0]              entry_vld,
    output logic [DEPTH-1:0][WIDTH-1:0]   entries
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; validity comes solely from the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Slot i is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset    = '0;
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset       = PTR_W'(i) - rd_ptr_q;
            entry_vld[i] = ({1'b0, offset} < count_q);
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign entries = mem_q;

endmodule

// File: rtl/wb_queue_stage.sv
// Write-back stage: queues aligned results in order and drains them one per
// cycle into the 8x16 register file, publishing a pending-write mask.
module wb_queue_stage
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [ADDR_W-1:0] in_rd0,
    input  logic [ADDR_W-1:0] in_rd1,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic              wb_stall,
    output logic              reg_write_en,
    output logic [1:0]        write_mode,
    output logic [ADDR_W-1:0] reg_write_addr_0,
    output logic [ADDR_W-1:0] reg_write_addr_1,
    output logic [DATA_W-1:0] data_in_0,
    output logic [DATA_W-1:0] data_in_1,
    output logic [7:0]        pending_mask,
    output logic              wb_empty
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = $bits(wb_entry_t);

    logic                              push, pop, empty;
    wb_entry_t                         cap_entry, head_entry;
    logic [ENTRY_W-1:0]                head_raw;
    logic [CNT_W-1:0]                  count;
    logic [DEPTH-1:0]                  entry_vld;
    logic [DEPTH-1:0][ENTRY_W-1:0]     entries;

    // in_ready depends only on occupancy, never on wb_stall or the pop.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign push      = in_valid & in_ready & (in_mode != WM_NONE);
    assign cap_entry = align_entry(in_mode, in_rd0, in_rd1, in_data0, in_data1);
    assign empty     = (count == '0);
    assign wb_empty  = empty;

    // Reset suppresses the write so discarded entries never reach the register file.
    assign reg_write_en = !empty & !wb_stall & !rst;
    assign pop          = reg_write_en;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cap_entry),
        .pop       (pop),
        .head      (head_raw),
        .count     (count),
        .entry_vld (entry_vld),
        .entries   (entries)
    );

    always_comb begin
        head_entry       = empty ? '0 : wb_entry_t'(head_raw);
        write_mode       = head_entry.mode;
        reg_write_addr_0 = head_entry.rd0;
        reg_write_addr_1 = head_entry.rd1;
        data_in_0        = head_entry.data0;
        data_in_1        = head_entry.data1;
    end

    always_comb begin
        wb_entry_t slot;
        slot         = '0;
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = wb_entry_t'(entries[i]);
            if (entry_vld[i]) begin
                pending_mask[slot.rd0] = 1'b1;
                if (slot.rd1 != '0) begin
                    pending_mask[slot.rd1] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_queue_stage.sv
// Directed bench for wb_queue_stage with hand-computed expectations.
module tb_wb_queue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [2:0]  in_rd0, in_rd1;
    logic [15:0] in_data0, in_data1;
    logic        wb_stall;
    logic        reg_write_en;
    logic [1:0]  write_mode;
    logic [2:0]  reg_write_addr_0, reg_write_addr_1;
    logic [15:0] data_in_0, data_in_1;
    logic [7:0]  pending_mask;
    logic        wb_empty;

    int checks   = 0;
    int failures = 0;
    int commit_cnt = 0;
    logic [15:0] commit_log[$];

    wb_queue_stage #(.DEPTH(2), .DATA_W(16), .ADDR_W(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_mode          (in_mode),
        .in_rd0           (in_rd0),
        .in_rd1           (in_rd1),
        .in_data0         (in_data0),
        .in_data1         (in_data1),
        .wb_stall         (wb_stall),
        .reg_write_en     (reg_write_en),
        .write_mode       (write_mode),
        .reg_write_addr_0 (reg_write_addr_0),
        .reg_write_addr_1 (reg_write_addr_1),
        .data_in_0        (data_in_0),
        .data_in_1        (data_in_1),
        .pending_mask     (pending_mask),
        .wb_empty         (wb_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_write_en) begin
            commit_cnt <= commit_cnt + 1;
            commit_log.push_back(data_in_0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [2:0] r0, input logic [2:0] r1,
                         input logic [15:0] d0, input logic [15:0] d1);
        in_valid = 1'b1;
        in_mode  = m;
        in_rd0   = r0;
        in_rd1   = r1;
        in_data0 = d0;
        in_data1 = d1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_mode  = 2'b00;
        in_rd0   = '0;
        in_rd1   = '0;
        in_data0 = '0;
        in_data1 = '0;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        wb_stall = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_wen",   reg_write_en, 0);
        chk("rst_mode",  write_mode, 0);
        chk("rst_a0",    reg_write_addr_0, 0);
        chk("rst_a1",    reg_write_addr_1, 0);
        chk("rst_d0",    data_in_0, 0);
        chk("rst_d1",    data_in_1, 0);
        chk("rst_mask",  pending_mask, 0);
        chk("rst_empty", wb_empty, 1);
        chk("rst_ready", in_ready, 1);

        // Single word write, one-cycle latency
        drive(2'b11, 3'd3, 3'd0, 16'hBEEF, 16'h0000);
        tick();
        idle();
        #1;
        chk("w_wen",  reg_write_en, 1);
        chk("w_mode", write_mode, 2'b11);
        chk("w_a0",   reg_write_addr_0, 3);
        chk("w_d0",   data_in_0, 16'hBEEF);
        chk("w_mask", pending_mask, 8'h08);
        tick();
        chk("w_wen2",   reg_write_en, 0);
        chk("w_empty2", wb_empty, 1);
        chk("w_mask2",  pending_mask, 8'h00);

        // High byte moves into upper half; rd1/data1 forced to zero
        drive(2'b10, 3'd5, 3'd7, 16'h12A7, 16'hFFFF);
        tick();
        idle();
        #1;
        chk("hi_d0",   data_in_0, 16'hA700);
        chk("hi_mode", write_mode, 2'b10);
        chk("hi_a1",   reg_write_addr_1, 0);
        chk("hi_d1",   data_in_1, 0);
        chk("hi_mask", pending_mask, 8'h20);
        tick();
        chk("hi_mask2", pending_mask, 8'h00);

        // Low byte keeps only [7:0]
        drive(2'b01, 3'd1, 3'd0, 16'hABCD, 16'h0000);
        tick();
        idle();
        #1;
        chk("lo_d0",   data_in_0, 16'h00CD);
        chk("lo_mask", pending_mask, 8'h02);
        tick();

        // Pair write, then duplicate destination collapses to single
        drive(2'b11, 3'd2, 3'd6, 16'h1111, 16'h2222);
        tick();
        idle();
        #1;
        chk("pr_mask", pending_mask, 8'h44);
        chk("pr_a0",   reg_write_addr_0, 2);
        chk("pr_a1",   reg_write_addr_1, 6);
        chk("pr_d1",   data_in_1, 16'h2222);
        tick();
        drive(2'b11, 3'd4, 3'd4, 16'h3333, 16'h4444);
        tick();
        idle();
        #1;
        chk("dup_a1",   reg_write_addr_1, 0);
        chk("dup_d1",   data_in_1, 0);
        chk("dup_mask", pending_mask, 8'h10);
        tick();

        // Full queue under stall, then drain in order
        base = commit_cnt;
        commit_log.delete();
        wb_stall = 1'b1;
        drive(2'b11, 3'd1, 3'd0, 16'h0A0A, 16'h0000);
        tick();
        drive(2'b11, 3'd2, 3'd0, 16'h0B0B, 16'h0000);
        #1;
        chk("fs_rdy1", in_ready, 1);
        tick();
        drive(2'b11, 3'd3, 3'd0, 16'h0C0C, 16'h0000);
        #1;
        chk("fs_rdy_full", in_ready, 0);
        chk("fs_wen",      reg_write_en, 0);
        chk("fs_mask",     pending_mask, 8'h06);
        tick();
        chk("fs_held", in_ready, 0);
        wb_stall = 1'b0;
        #1;
        chk("fs_wenA", reg_write_en, 1);
        chk("fs_dA",   data_in_0, 16'h0A0A);
        tick();
        chk("fs_dB",   data_in_0, 16'h0B0B);
        chk("fs_rdyB", in_ready, 1);
        tick();
        idle();
        #1;
        chk("fs_dC", data_in_0, 16'h0C0C);
        tick();
        chk("fs_empty",   wb_empty, 1);
        chk("fs_commits", commit_cnt - base, 3);
        chk("fs_logA", (commit_log.size() > 0) ? commit_log[0] : 16'hDEAD, 16'h0A0A);
        chk("fs_logB", (commit_log.size() > 1) ? commit_log[1] : 16'hDEAD, 16'h0B0B);
        chk("fs_logC", (commit_log.size() > 2) ? commit_log[2] : 16'hDEAD, 16'h0C0C);

        // Mode 00 consumes no slot
        base = commit_cnt;
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 3'd5, 3'd6, 16'h5555, 16'h6666);
            #1;
            chk("m0_rdy", in_ready, 1);
            chk("m0_empty", wb_empty, 1);
            chk("m0_wen", reg_write_en, 0);
            tick();
        end
        idle();
        #1;
        chk("m0_empty_end", wb_empty, 1);
        chk("m0_commits", commit_cnt - base, 0);

        // Reset with two queued entries discards them
        base = commit_cnt;
        wb_stall = 1'b1;
        drive(2'b11, 3'd5, 3'd0, 16'h5151, 16'h0000);
        tick();
        drive(2'b11, 3'd6, 3'd0, 16'h6161, 16'h0000);
        tick();
        idle();
        #1;
        chk("mr_mask", pending_mask, 8'h60);
        chk("mr_full", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mr_wen_dur", reg_write_en, 0);
        tick();
        rst = 1'b0;
        wb_stall = 1'b0;
        #1;
        chk("mr_wen",   reg_write_en, 0);
        chk("mr_mask0", pending_mask, 8'h00);
        chk("mr_empty", wb_empty, 1);
        chk("mr_ready", in_ready, 1);
        tick();
        tick();
        chk("mr_wen2",    reg_write_en, 0);
        chk("mr_commits", commit_cnt - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
